// File: rtl/bpc_lane_arbiter.sv
// bpc_lane_arbiter: block-level round-robin arbiter that shares one BPC code
// buffer among NUM_LANES encoder lanes. One lane is granted for one complete
// block (sop .. eop), its beats are forwarded with a one-cycle register stage,
// and no new grant is issued until the code buffer reports the block size.
// Optional drain watchdog: define BPC_ARB_TIMEOUT_EN (limit TIMEOUT_CYC).

module bpc_lane_arbiter #(
    parameter int  NUM_LANES   = 4,
    parameter int  DATA_W      = 152,
    parameter int  SIZE_W      = 8,
    parameter int  TIMEOUT_CYC = 64,
    localparam int LANE_W      = $clog2(NUM_LANES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_LANES*DATA_W-1:0]   lane_data_i,
    input  logic [NUM_LANES*SIZE_W-1:0]   lane_size_i,
    input  logic [NUM_LANES-1:0]          lane_valid_i,
    input  logic [NUM_LANES-1:0]          lane_sop_i,
    input  logic [NUM_LANES-1:0]          lane_eop_i,
    output logic [NUM_LANES-1:0]          lane_ready_o,
    output logic [DATA_W-1:0]             cb_data_o,
    output logic [SIZE_W-1:0]             cb_size_o,
    output logic                          cb_valid_o,
    output logic                          cb_sop_o,
    output logic                          cb_eop_o,
    input  logic                          cb_s_valid_i,
    input  logic [10:0]                   cb_size_i,
    output logic                          done_valid_o,
    output logic [LANE_W-1:0]             done_lane_o,
    output logic [10:0]                   done_size_o,
    output logic                          err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [LANE_W-1:0]     grant, last_grant, cand_idx;
    logic                  first_beat;
    logic [NUM_LANES-1:0]  cand;
    logic                  cand_found, accept, beat_sop, beat_eop;
    logic                  wd_expire, err_set;
    logic [DATA_W-1:0]     lane_data [NUM_LANES];
    logic [SIZE_W-1:0]     lane_size [NUM_LANES];

    // First requester strictly after 'last' in circular order; 'last' itself
    // is checked last so a lone requester can win twice in a row.
    function automatic logic [LANE_W-1:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                                  input logic [LANE_W-1:0]    last);
        logic [LANE_W-1:0] pick;
        logic [LANE_W-1:0] cur;
        logic              hit;
        int                idx;
        pick = last;
        hit  = 1'b0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            cur = LANE_W'(idx);
            if (!hit && req[cur]) begin
                hit  = 1'b1;
                pick = cur;
            end
        end
        return pick;
    endfunction

    // Unpack the flat lane buses into per-lane arrays for indexed selection.
    always_comb begin
        for (int g = 0; g < NUM_LANES; g++) begin
            lane_data[g] = lane_data_i[g*DATA_W +: DATA_W];
            lane_size[g] = lane_size_i[g*SIZE_W +: SIZE_W];
        end
    end

    // Arbitration candidates, granted-lane beat decode and lane ready.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would infer a latch.
        lane_ready_o = '0;
        cand         = lane_valid_i & lane_sop_i;
        cand_found   = |cand;
        cand_idx     = rr_pick(cand, last_grant);
        accept       = (state == S_STREAM) && lane_valid_i[grant];
        beat_sop     = lane_sop_i[grant];
        beat_eop     = lane_eop_i[grant];
        if (state == S_STREAM) lane_ready_o[grant] = 1'b1;
    end

`ifdef BPC_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Drain watchdog: held at zero outside DRAIN so each DRAIN starts from 0.
    always_ff @(posedge clk) begin
        if (!rst_n)                wd_cnt <= '0;
        else if (state != S_DRAIN) wd_cnt <= '0;
        else                       wd_cnt <= wd_cnt + WD_W'(1);
    end

    // The count reaching the limit this cycle ends the drain; a real s_valid
    // in the same cycle takes priority.
    assign wd_expire = (state == S_DRAIN) && !cb_s_valid_i &&
                       (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state logic and protocol error detection.
    always_comb begin
        state_next = state;
        err_set    = (accept && (first_beat ? !beat_sop : beat_sop)) ||
                     (cb_s_valid_i && (state != S_DRAIN)) ||
                     wd_expire;
        unique case (state)
            S_IDLE:   if (cand_found)                 state_next = S_STREAM;
            S_STREAM: if (accept && beat_eop)         state_next = S_DRAIN;
            S_DRAIN:  if (cb_s_valid_i || wd_expire)  state_next = S_IDLE;
            default:                                  state_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Grant bookkeeping, beat forwarding, done reporting and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant        <= '0;
            last_grant   <= LANE_W'(NUM_LANES - 1);
            first_beat   <= 1'b0;
            cb_data_o    <= '0;
            cb_size_o    <= '0;
            cb_valid_o   <= 1'b0;
            cb_sop_o     <= 1'b0;
            cb_eop_o     <= 1'b0;
            done_valid_o <= 1'b0;
            done_lane_o  <= '0;
            done_size_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            cb_data_o    <= '0;
            cb_size_o    <= '0;
            cb_valid_o   <= 1'b0;
            cb_sop_o     <= 1'b0;
            cb_eop_o     <= 1'b0;
            done_valid_o <= 1'b0;

            if (state == S_IDLE && cand_found) begin
                grant      <= cand_idx;
                last_grant <= cand_idx;
                first_beat <= 1'b1;
            end

            if (accept) begin
                cb_data_o  <= lane_data[grant];
                cb_size_o  <= lane_size[grant];
                cb_valid_o <= 1'b1;
                cb_sop_o   <= beat_sop;
                cb_eop_o   <= beat_eop;
                first_beat <= 1'b0;
            end

            if (state == S_DRAIN && cb_s_valid_i) begin
                done_valid_o <= 1'b1;
                done_lane_o  <= grant;
                done_size_o  <= cb_size_i;
            end else if (wd_expire) begin
                done_valid_o <= 1'b1;
                done_lane_o  <= grant;
                done_size_o  <= '0;
            end

            if (err_set) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bpc_lane_arbiter.sv
// Directed self-checking bench for bpc_lane_arbiter. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// Define BPC_ARB_TIMEOUT_EN for both RTL and bench to exercise the watchdog.

module tb_bpc_lane_arbiter;

    localparam int NUM_LANES   = 4;
    localparam int DATA_W      = 152;
    localparam int SIZE_W      = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int LANE_W      = 2;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_LANES*DATA_W-1:0] lane_data_i;
    logic [NUM_LANES*SIZE_W-1:0] lane_size_i;
    logic [NUM_LANES-1:0]        lane_valid_i;
    logic [NUM_LANES-1:0]        lane_sop_i;
    logic [NUM_LANES-1:0]        lane_eop_i;
    logic [NUM_LANES-1:0]        lane_ready_o;
    logic [DATA_W-1:0]           cb_data_o;
    logic [SIZE_W-1:0]           cb_size_o;
    logic                        cb_valid_o;
    logic                        cb_sop_o;
    logic                        cb_eop_o;
    logic                        cb_s_valid_i;
    logic [10:0]                 cb_size_i;
    logic                        done_valid_o;
    logic [LANE_W-1:0]           done_lane_o;
    logic [10:0]                 done_size_o;
    logic                        err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bpc_lane_arbiter #(
        .NUM_LANES  (NUM_LANES),
        .DATA_W     (DATA_W),
        .SIZE_W     (SIZE_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lane_data_i (lane_data_i),
        .lane_size_i (lane_size_i),
        .lane_valid_i(lane_valid_i),
        .lane_sop_i  (lane_sop_i),
        .lane_eop_i  (lane_eop_i),
        .lane_ready_o(lane_ready_o),
        .cb_data_o   (cb_data_o),
        .cb_size_o   (cb_size_o),
        .cb_valid_o  (cb_valid_o),
        .cb_sop_o    (cb_sop_o),
        .cb_eop_o    (cb_eop_o),
        .cb_s_valid_i(cb_s_valid_i),
        .cb_size_i   (cb_size_i),
        .done_valid_o(done_valid_o),
        .done_lane_o (done_lane_o),
        .done_size_o (done_size_o),
        .err_o       (err_o)
    );

    // Distinct payload per (lane, beat), with marker bits at the top of the word.
    function automatic logic [DATA_W-1:0] mk_data(input int lane, input int beat);
        logic [DATA_W-1:0] d;
        d                 = '0;
        d[15:8]           = 8'(lane);
        d[7:0]            = 8'(beat);
        d[DATA_W-2 -: 8]  = 8'hA5;
        d[DATA_W-1]       = 1'b1;
        return d;
    endfunction

    task automatic set_lane(input int lane, input logic v, input logic s, input logic e,
                            input int size, input int beat);
        lane_valid_i[lane]                  = v;
        lane_sop_i[lane]                    = s;
        lane_eop_i[lane]                    = e;
        lane_size_i[lane*SIZE_W +: SIZE_W]  = SIZE_W'(size);
        lane_data_i[lane*DATA_W +: DATA_W]  = mk_data(lane, beat);
    endtask

    task automatic clear_lanes();
        lane_valid_i = '0;
        lane_sop_i   = '0;
        lane_eop_i   = '0;
        lane_size_i  = '0;
        lane_data_i  = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n        = 1'b0;
        cb_s_valid_i = 1'b0;
        cb_size_i    = '0;
        clear_lanes();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (lane_ready_o !== 4'b0000 || cb_valid_o !== 1'b0 || cb_sop_o !== 1'b0 ||
            cb_eop_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b cb_v/s/e=%b%b%b expected 0000 000",
                     lane_ready_o, cb_valid_o, cb_sop_o, cb_eop_o);
        end
        checks++;
        if (cb_data_o !== '0 || cb_size_o !== '0) begin
            errors++;
            $display("FAIL reset_cb_bus: data=%h size=%0d expected 0", cb_data_o, cb_size_o);
        end
        checks++;
        if (done_valid_o !== 1'b0 || done_lane_o !== 2'd0 || done_size_o !== 11'd0 ||
            err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: dv=%b lane=%0d size=%0d err=%b expected all 0",
                     done_valid_o, done_lane_o, done_size_o, err_o);
        end
    endtask

    task automatic test_single_lane();
        int sizes [4];
        sizes = '{100, 100, 100, 60};
        reset_dut();
        set_lane(0, 1'b1, 1'b1, 1'b0, sizes[0], 0);
        @(negedge clk);
        checks++;
        if (lane_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: ready=%b expected 0001", lane_ready_o);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (cb_valid_o !== 1'b1 || cb_sop_o !== (b == 0) || cb_eop_o !== (b == 3) ||
                cb_size_o !== SIZE_W'(sizes[b]) || cb_data_o !== mk_data(0, b)) begin
                errors++;
                $display("FAIL single_beat%0d: v=%b sop=%b eop=%b size=%0d data=%h expected 1 %b %b %0d %h",
                         b, cb_valid_o, cb_sop_o, cb_eop_o, cb_size_o, cb_data_o,
                         (b == 0), (b == 3), sizes[b], mk_data(0, b));
            end
            if (b < 3) set_lane(0, 1'b1, 1'b0, (b + 1 == 3), sizes[b+1], b + 1);
            else       clear_lanes();
        end
        checks++;
        if (lane_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_drain_ready: ready=%b expected 0000", lane_ready_o);
        end
        @(negedge clk);
        checks++;
        if (cb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_cb_idle: cb_valid=%b expected 0", cb_valid_o);
        end
        cb_s_valid_i = 1'b1;
        cb_size_i    = 11'd360;
        @(negedge clk);
        cb_s_valid_i = 1'b0;
        checks++;
        if (done_valid_o !== 1'b1 || done_lane_o !== 2'd0 || done_size_o !== 11'd360 ||
            err_o !== 1'b0) begin
            errors++;
            $display("FAIL single_done: dv=%b lane=%0d size=%0d err=%b expected 1 0 360 0",
                     done_valid_o, done_lane_o, done_size_o, err_o);
        end
        @(negedge clk);
        checks++;
        if (done_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: dv=%b expected 0", done_valid_o);
        end
    endtask

    task automatic test_round_robin();
        logic [LANE_W-1:0] exp_lane [4];
        exp_lane = '{2'd0, 2'd1, 2'd3, 2'd0};
        reset_dut();
        set_lane(0, 1'b1, 1'b1, 1'b1, 16, 0);
        set_lane(1, 1'b1, 1'b1, 1'b1, 16, 0);
        set_lane(3, 1'b1, 1'b1, 1'b1, 16, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (lane_ready_o !== (4'b0001 << exp_lane[k])) begin
                errors++;
                $display("FAIL rr_grant%0d: ready=%b expected lane %0d", k, lane_ready_o, exp_lane[k]);
            end
            @(negedge clk);
            checks++;
            if (lane_ready_o !== 4'b0000 || cb_eop_o !== 1'b1 ||
                cb_data_o !== mk_data(int'(exp_lane[k]), 0)) begin
                errors++;
                $display("FAIL rr_beat%0d: ready=%b eop=%b data=%h expected 0000 1 %h",
                         k, lane_ready_o, cb_eop_o, cb_data_o, mk_data(int'(exp_lane[k]), 0));
            end
            @(negedge clk);
            checks++;
            if (lane_ready_o !== 4'b0000) begin
                errors++;
                $display("FAIL rr_drain%0d: ready=%b expected 0000", k, lane_ready_o);
            end
            cb_s_valid_i = 1'b1;
            cb_size_i    = 11'(20 + k);
            @(negedge clk);
            cb_s_valid_i = 1'b0;
            if (k == 3) clear_lanes();
            checks++;
            if (done_valid_o !== 1'b1 || done_lane_o !== exp_lane[k] ||
                done_size_o !== 11'(20 + k) || lane_ready_o !== 4'b0000) begin
                errors++;
                $display("FAIL rr_done%0d: dv=%b lane=%0d size=%0d ready=%b expected 1 %0d %0d 0000",
                         k, done_valid_o, done_lane_o, done_size_o, lane_ready_o, exp_lane[k], 20 + k);
            end
        end
    endtask

    task automatic test_bubbles();
        reset_dut();
        set_lane(0, 1'b1, 1'b1, 1'b0, 50, 0);
        set_lane(1, 1'b1, 1'b1, 1'b1, 7, 0);
        set_lane(2, 1'b1, 1'b1, 1'b1, 7, 0);
        @(negedge clk);
        checks++;
        if (lane_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL bub_grant: ready=%b expected 0001", lane_ready_o);
        end
        @(negedge clk);
        checks++;
        if (cb_valid_o !== 1'b1 || cb_data_o !== mk_data(0, 0) || cb_size_o !== 8'd50) begin
            errors++;
            $display("FAIL bub_first: v=%b data=%h size=%0d expected 1 %h 50",
                     cb_valid_o, cb_data_o, cb_size_o, mk_data(0, 0));
        end
        set_lane(0, 1'b0, 1'b0, 1'b0, 0, 9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cb_valid_o !== 1'b0 || lane_ready_o !== 4'b0001) begin
                errors++;
                $display("FAIL bub_gap%0d: cb_valid=%b ready=%b expected 0 0001",
                         i, cb_valid_o, lane_ready_o);
            end
        end
        set_lane(0, 1'b1, 1'b0, 1'b1, 30, 1);
        @(negedge clk);
        checks++;
        if (cb_valid_o !== 1'b1 || cb_sop_o !== 1'b0 || cb_eop_o !== 1'b1 ||
            cb_data_o !== mk_data(0, 1) || cb_size_o !== 8'd30 || lane_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL bub_last: v=%b sop=%b eop=%b data=%h size=%0d ready=%b expected 1 0 1 %h 30 0000",
                     cb_valid_o, cb_sop_o, cb_eop_o, cb_data_o, cb_size_o, lane_ready_o, mk_data(0, 1));
        end
        @(negedge clk);
        cb_s_valid_i = 1'b1;
        cb_size_i    = 11'd80;
        @(negedge clk);
        cb_s_valid_i = 1'b0;
        clear_lanes();
        checks++;
        if (done_valid_o !== 1'b1 || done_lane_o !== 2'd0 || done_size_o !== 11'd80 ||
            err_o !== 1'b0) begin
            errors++;
            $display("FAIL bub_done: dv=%b lane=%0d size=%0d err=%b expected 1 0 80 0",
                     done_valid_o, done_lane_o, done_size_o, err_o);
        end
    endtask

    task automatic test_protocol_errors();
        reset_dut();
        set_lane(2, 1'b1, 1'b1, 1'b0, 10, 0);
        @(negedge clk);
        checks++;
        if (lane_ready_o !== 4'b0100 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL perr_grant: ready=%b err=%b expected 0100 0", lane_ready_o, err_o);
        end
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0 || cb_sop_o !== 1'b1) begin
            errors++;
            $display("FAIL perr_clean_sop: err=%b sop=%b expected 0 1", err_o, cb_sop_o);
        end
        set_lane(2, 1'b1, 1'b1, 1'b0, 10, 1);
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || cb_valid_o !== 1'b1 || cb_sop_o !== 1'b1 ||
            cb_data_o !== mk_data(2, 1)) begin
            errors++;
            $display("FAIL perr_dup_sop: err=%b v=%b sop=%b data=%h expected 1 1 1 %h",
                     err_o, cb_valid_o, cb_sop_o, cb_data_o, mk_data(2, 1));
        end
        set_lane(2, 1'b1, 1'b0, 1'b1, 10, 2);
        @(negedge clk);
        clear_lanes();
        @(negedge clk);
        cb_s_valid_i = 1'b1;
        cb_size_i    = 11'd30;
        @(negedge clk);
        cb_s_valid_i = 1'b0;
        checks++;
        if (done_valid_o !== 1'b1 || done_lane_o !== 2'd2 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL perr_done: dv=%b lane=%0d err=%b expected 1 2 1",
                     done_valid_o, done_lane_o, err_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: err=%b expected 1", err_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL perr_reset_clear: err=%b expected 0", err_o);
        end
        @(negedge clk);
        cb_s_valid_i = 1'b1;
        cb_size_i    = 11'd5;
        @(negedge clk);
        cb_s_valid_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || done_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL perr_idle_svalid: err=%b dv=%b expected 1 0", err_o, done_valid_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL perr_idle_sticky: err=%b expected 1", err_o);
        end
    endtask

    task automatic test_reset_stream();
        reset_dut();
        set_lane(2, 1'b1, 1'b1, 1'b0, 20, 0);
        @(negedge clk);
        @(negedge clk);
        set_lane(2, 1'b1, 1'b0, 1'b0, 20, 1);
        @(negedge clk);
        checks++;
        if (cb_valid_o !== 1'b1 || cb_data_o !== mk_data(2, 1)) begin
            errors++;
            $display("FAIL rst_mid_beat2: v=%b data=%h expected 1 %h", cb_valid_o, cb_data_o, mk_data(2, 1));
        end
        rst_n = 1'b0;
        for (int g = 0; g < NUM_LANES; g++) set_lane(g, 1'b1, 1'b1, 1'b0, 20, g);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (lane_ready_o !== 4'b0000 || cb_valid_o !== 1'b0 || cb_sop_o !== 1'b0 ||
            cb_eop_o !== 1'b0 || cb_data_o !== '0 || cb_size_o !== '0 ||
            done_valid_o !== 1'b0 || done_lane_o !== 2'd0 || done_size_o !== 11'd0 ||
            err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b v=%b data=%h dv=%b err=%b expected all 0",
                     lane_ready_o, cb_valid_o, cb_data_o, done_valid_o, err_o);
        end
        @(negedge clk);
        checks++;
        if (lane_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_regrant: ready=%b expected 0001", lane_ready_o);
        end
    endtask

    task automatic test_drain_watchdog();
        reset_dut();
        set_lane(1, 1'b1, 1'b1, 1'b1, 12, 0);
        @(negedge clk);
        checks++;
        if (lane_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL drain_grant: ready=%b expected 0010", lane_ready_o);
        end
        @(negedge clk);
        clear_lanes();
`ifdef BPC_ARB_TIMEOUT_EN
        begin
            int cnt;
            cnt = 0;
            while (cnt < 40) begin
                @(negedge clk);
                cnt++;
                if (done_valid_o) break;
            end
            checks++;
            if (done_valid_o !== 1'b1 || cnt != TIMEOUT_CYC) begin
                errors++;
                $display("FAIL wd_timing: dv=%b after %0d cycles expected 1 after %0d",
                         done_valid_o, cnt, TIMEOUT_CYC);
            end
            checks++;
            if (done_size_o !== 11'd0 || done_lane_o !== 2'd1 || err_o !== 1'b1) begin
                errors++;
                $display("FAIL wd_report: size=%0d lane=%0d err=%b expected 0 1 1",
                         done_size_o, done_lane_o, err_o);
            end
        end
`else
        begin
            logic seen;
            seen = 1'b0;
            set_lane(0, 1'b1, 1'b1, 1'b1, 12, 0);
            repeat (40) begin
                @(negedge clk);
                if (done_valid_o || lane_ready_o != 4'b0000) seen = 1'b1;
            end
            checks++;
            if (seen !== 1'b0) begin
                errors++;
                $display("FAIL drain_wait: early done or ready seen=%b expected 0", seen);
            end
            cb_s_valid_i = 1'b1;
            cb_size_i    = 11'd99;
            @(negedge clk);
            cb_s_valid_i = 1'b0;
            clear_lanes();
            checks++;
            if (done_valid_o !== 1'b1 || done_lane_o !== 2'd1 || done_size_o !== 11'd99 ||
                err_o !== 1'b0) begin
                errors++;
                $display("FAIL drain_done: dv=%b lane=%0d size=%0d err=%b expected 1 1 99 0",
                         done_valid_o, done_lane_o, done_size_o, err_o);
            end
        end
`endif
    endtask

    // Absolute time bound so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        cb_s_valid_i = 1'b0;
        cb_size_i    = '0;
        clear_lanes();
        test_reset();
        test_single_lane();
        test_round_robin();
        test_bubbles();
        test_protocol_errors();
        test_reset_stream();
        test_drain_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
